// File: rtl/int2flt_pkg.sv
// Shared types and helpers for the iterative integer-to-float converter.
package int2flt_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ABS   = 3'd1,
    NORM  = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic RND_TRUNC = 1'b0;
  localparam logic RND_RNE   = 1'b1;

  // Exponent bias for an EXP_W-bit exponent field.
  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/int2flt_iter_round.sv
// Combinational rounding: optional round-to-nearest-even, mantissa carry into
// the exponent, and saturation to the largest finite value on overflow.
module flt_round
  import int2flt_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic [MAN_W-1:0] mant_in,
  input  logic [EXP_W-1:0] exp_in,
  input  logic             guard,
  input  logic             sticky,
  input  logic             rnd_mode,
  output logic [MAN_W-1:0] mant_out,
  output logic [EXP_W-1:0] exp_out,
  output logic             ovf
);

  logic             inc;
  logic [MAN_W:0]   sum;
  logic [EXP_W-1:0] exp_c;

  // Round, propagate the carry, then clamp an all-ones exponent back to max finite.
  always_comb begin
    inc      = (rnd_mode == RND_RNE) & guard & (mant_in[0] | sticky);
    sum      = {1'b0, mant_in} + {{MAN_W{1'b0}}, inc};
    exp_c    = exp_in + EXP_W'(sum[MAN_W]);
    mant_out = sum[MAN_W] ? '0 : sum[MAN_W-1:0];
    exp_out  = exp_c;
    ovf      = 1'b0;
    // Only a rounding carry can reach all-ones: the pre-round exponent is bounded.
    if (exp_c == '1) begin
      exp_out  = {{(EXP_W-1){1'b1}}, 1'b0};
      mant_out = '1;
      ovf      = 1'b1;
    end
  end

endmodule

// File: rtl/int2flt_iter.sv
// Iterative integer-to-float coprocessor: start/done handshake, one-bit-per-cycle
// normalisation, selectable signedness and rounding, saturating overflow.
module int2flt_iter
  import int2flt_pkg::*;
#(
  parameter int INT_W = 16,
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [INT_W-1:0]       int_in,
  input  logic                   is_signed,
  input  logic                   rnd_mode,
  output logic [EXP_W+MAN_W:0]   flt_out,
  output logic                   done,
  output logic                   busy,
  output logic                   ovf
);

  localparam int BIAS = bias(EXP_W);
  localparam int LZW  = $clog2(INT_W + 1);
  localparam int XW   = INT_W + MAN_W;

  if (BIAS + INT_W - 1 > (1 << EXP_W) - 2 || MAN_W < 1 || INT_W < 2) begin : g_bad_cfg
    $error("int2flt_iter: exponent range too small for INT_W, or MAN_W/INT_W too small");
  end

  state_t           state;
  logic [INT_W-1:0] op_q;
  logic             op_signed_q;
  logic             rnd_q;
  logic             sign_q;
  logic [INT_W-1:0] mag_q;
  logic [LZW-1:0]   lz_q;

  logic             abs_sign;
  logic [INT_W-1:0] abs_mag;
  logic [XW-1:0]    frac;
  logic [MAN_W-1:0] mant_t;
  logic [EXP_W-1:0] exp_pre;
  logic             guard;
  logic             sticky;
  logic [MAN_W-1:0] mant_r;
  logic [EXP_W-1:0] exp_r;
  logic             ovf_r;

  // Sign/magnitude of the captured operand; most-negative wraps to 2**(INT_W-1).
  always_comb begin
    abs_sign = op_signed_q & op_q[INT_W-1];
    abs_mag  = abs_sign ? ({INT_W{1'b0}} - op_q) : op_q;
  end

  // Fraction bits below the leading one, zero-padded so mant/guard/sticky always exist.
  always_comb begin
    frac    = {mag_q[INT_W-2:0], {(MAN_W+1){1'b0}}};
    mant_t  = frac[XW-1 -: MAN_W];
    guard   = frac[XW-1-MAN_W];
    sticky  = |frac[XW-2-MAN_W:0];
    exp_pre = EXP_W'(BIAS + INT_W - 1 - int'(lz_q));
  end

  flt_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
    .mant_in  (mant_t),
    .exp_in   (exp_pre),
    .guard    (guard),
    .sticky   (sticky),
    .rnd_mode (rnd_q),
    .mant_out (mant_r),
    .exp_out  (exp_r),
    .ovf      (ovf_r)
  );

  // Control FSM with operand capture, normalising shifter and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      op_q        <= '0;
      op_signed_q <= 1'b0;
      rnd_q       <= 1'b0;
      sign_q      <= 1'b0;
      mag_q       <= '0;
      lz_q        <= '0;
      flt_out     <= '0;
      ovf         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q        <= int_in;
            op_signed_q <= is_signed;
            rnd_q       <= rnd_mode;
            state       <= ABS;
          end
        end
        ABS: begin
          sign_q <= abs_sign;
          mag_q  <= abs_mag;
          lz_q   <= '0;
          if (abs_mag == '0) begin
            // Zero skips normalisation; sign is forced positive.
            flt_out <= '0;
            ovf     <= 1'b0;
            state   <= DONE;
          end else if (abs_mag[INT_W-1]) begin
            state <= ROUND;
          end else begin
            state <= NORM;
          end
        end
        NORM: begin
          // Leave as soon as the shift brings the leading one into the MSB.
          if (mag_q[INT_W-1]) begin
            state <= ROUND;
          end else begin
            mag_q <= mag_q << 1;
            lz_q  <= lz_q + LZW'(1);
            if (mag_q[INT_W-2]) state <= ROUND;
          end
        end
        ROUND: begin
          flt_out <= {sign_q, exp_r, mant_r};
          ovf     <= ovf_r;
          state   <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign done = (state == DONE);
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_int2flt_iter.sv
// Self-checking bench: arithmetic reference model plus per-cycle output compare.
module tb_int2flt_iter;

  localparam int INT_W = 16;
  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int BIAS  = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] int_in = '0;
  logic        is_signed = 1'b1;
  logic        rnd_mode = 1'b1;
  logic [15:0] flt_out;
  logic        done;
  logic        busy;
  logic        ovf;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // model state shared between driver and compare process
  bit          pend = 1'b0;
  int          acc_cyc = 0;
  int          done_at = 0;
  logic [15:0] m_flt = '0;
  bit          m_ovf = 1'b0;
  int          m_lat = 0;
  logic [15:0] held_flt = '0;
  bit          held_ovf = 1'b0;

  int2flt_iter #(.INT_W(INT_W), .EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .int_in    (int_in),
    .is_signed (is_signed),
    .rnd_mode  (rnd_mode),
    .flt_out   (flt_out),
    .done      (done),
    .busy      (busy),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Value-level conversion: find the leading one, scale the fraction, round on remainder.
  function automatic void model(input logic [15:0] v, input bit s, input bit r,
                                output logic [15:0] f, output bit o, output int lat);
    longint m, frac, mant, rem, half;
    int p, e, sh;
    bit neg;
    neg = s && v[15];
    m = neg ? (longint'(65536) - longint'(v)) : longint'(v);
    o = 1'b0;
    f = '0;
    lat = 2;
    if (m == 0) return;
    p = 0;
    for (int i = 0; i < 17; i++) if (m >= (longint'(1) << i)) p = i;
    lat = 3 + (INT_W - 1 - p);
    e = BIAS + p;
    frac = m - (longint'(1) << p);
    if (p <= MAN_W) begin
      mant = frac << (MAN_W - p);
    end else begin
      sh = p - MAN_W;
      mant = frac >> sh;
      rem = frac % (longint'(1) << sh);
      half = longint'(1) << (sh - 1);
      if (r && (rem > half || (rem == half && (mant % 2) == 1))) mant++;
    end
    if (mant == (longint'(1) << MAN_W)) begin
      mant = 0;
      e++;
    end
    if (e >= (1 << EXP_W) - 1) begin
      e = (1 << EXP_W) - 2;
      mant = (longint'(1) << MAN_W) - 1;
      o = 1'b1;
    end
    f = {neg, 5'(e), 10'(mant)};
  endfunction

  // Per-cycle compare of done/busy/flt_out/ovf against the model state.
  initial begin
    bit r;
    forever begin
      @(posedge clk);
      r = reset;
      #1;
      if (r) begin
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_flt", 32'(flt_out), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
      end else if (pend) begin
        chk("busy", 32'(busy), 32'(cyc > acc_cyc));
        chk("done", 32'(done), 32'(cyc == done_at));
        if (cyc == done_at) begin
          chk("flt_out", 32'(flt_out), 32'(m_flt));
          chk("ovf", 32'(ovf), 32'(m_ovf));
          held_flt = m_flt;
          held_ovf = m_ovf;
          pend = 1'b0;
        end
      end else begin
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("held_flt", 32'(flt_out), 32'(held_flt));
        chk("held_ovf", 32'(ovf), 32'(held_ovf));
      end
    end
  end

  // Called at a negedge while the DUT is idle; returns one negedge later.
  task automatic start_op(input logic [15:0] v, input bit s, input bit r);
    int_in = v;
    is_signed = s;
    rnd_mode = r;
    start = 1'b1;
    model(v, s, r, m_flt, m_ovf, m_lat);
    acc_cyc = cyc;
    done_at = cyc + m_lat;
    pend = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns at the negedge of the done cycle, or flags a timeout.
  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic lit_op(input string name, input logic [15:0] v, input bit s, input bit r,
                        input logic [15:0] lf, input bit lo);
    start_op(v, s, r);
    wait_done();
    chk({name, "_dut"}, 32'(flt_out), 32'(lf));
    chk({name, "_ovf"}, 32'(ovf), 32'(lo));
    chk({name, "_model"}, 32'(m_flt), 32'(lf));
    @(negedge clk);
  endtask

  initial begin
    int t0;
    logic [15:0] v;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // latency pins
    t0 = cyc;
    start_op(16'h0001, 1'b1, 1'b1);
    wait_done();
    chk("lat_one", 32'(cyc - t0), 32'd18);
    chk("one_flt", 32'(flt_out), 32'h3C00);
    @(negedge clk);
    t0 = cyc;
    start_op(16'h0000, 1'b1, 1'b1);
    wait_done();
    chk("lat_zero", 32'(cyc - t0), 32'd2);
    chk("zero_flt", 32'(flt_out), 32'h0000);
    @(negedge clk);

    lit_op("mostneg",  16'h8000, 1'b1, 1'b1, 16'hF800, 1'b0);
    lit_op("neg12",    16'hFFF4, 1'b1, 1'b1, 16'hCA00, 1'b0);
    lit_op("fff_rne",  16'h0FFF, 1'b1, 1'b1, 16'h6C00, 1'b0);
    lit_op("fff_trc",  16'h0FFF, 1'b1, 1'b0, 16'h6BFF, 1'b0);
    lit_op("tie_even", 16'h0801, 1'b1, 1'b1, 16'h6800, 1'b0);
    lit_op("u8000",    16'h8000, 1'b0, 1'b1, 16'h7800, 1'b0);
    lit_op("sat_rne",  16'hFFF0, 1'b0, 1'b1, 16'h7BFF, 1'b1);
    lit_op("sat_trc",  16'hFFF0, 1'b0, 1'b0, 16'h7BFF, 1'b0);

    // start while busy is ignored
    start_op(16'h0003, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    int_in = 16'h7FFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    chk("busy_ign", 32'(flt_out), 32'h4200);
    // start in done cycle ignored, cycle after done accepted
    int_in = 16'h1234;
    start = 1'b1;
    @(negedge clk);
    start_op(16'h0005, 1'b1, 1'b1);
    wait_done();
    chk("b2b", 32'(flt_out), 32'h4500);
    @(negedge clk);

    // reset during NORM abandons the operation
    start_op(16'h0001, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    pend = 1'b0;
    held_flt = '0;
    held_ovf = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    repeat (25) @(negedge clk);

    // random operands
    for (int k = 0; k < 200; k++) begin
      v = 16'($urandom) >> $urandom_range(0, 15);
      if ($urandom_range(0, 7) == 0) v = 16'hFFFF - 16'($urandom_range(0, 40));
      start_op(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait_done();
      @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
